// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder_if
// Purpose  : Operand/result bus for pipelined_adder. Carries the input
//            handshake (in_valid/in_ready), the operands (a, b, sub, cin),
//            the output handshake (out_valid/out_ready) and the result
//            (sum plus cout/ovf/zero/neg flags).
// Modports : master - operand source and result consumer
//            slave  - the adder itself
// Revision : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output in_valid, a, b, sub, cin, out_ready,
      input  in_ready, out_valid, sum, cout, ovf, zero, neg
   );

   modport slave (
      input  in_valid, a, b, sub, cin, out_ready,
      output in_ready, out_valid, sum, cout, ovf, zero, neg
   );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_adder
// Purpose  : WIDTH-bit add/subtract split into STAGES equal chunks; one chunk
//            is resolved per pipeline stage with the carry registered between
//            stages. Valid/ready flow control, whole-pipe stall.
// Ports    : clk  - clock, rising edge
//            rst  - synchronous active-high reset
//            bus  - pipelined_adder_if.slave (operands in, result/flags out)
// Revision : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   pipelined_adder_if.slave   bus
);
   localparam int CW   = WIDTH / STAGES;
   localparam int LAST = STAGES - 1;
   localparam int MSB  = WIDTH - 1;

   logic             adv;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] c_q, c_d;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic [CW:0]       chunk [STAGES];
   logic              cin0;
   logic              ovf_q, ovf_d;
   logic              zero_q, zero_d;
   logic              neg_q, neg_d;

   always_comb begin
      // The whole pipe moves together whenever the output slot is free.
      adv = !valid_q[LAST] || bus.out_ready;

      // Stage 0: capture operands (zeroed for bubbles so empty slots never
      // leak stale data to the outputs) and resolve chunk 0.
      valid_d[0] = bus.in_valid;
      a_d[0]     = bus.in_valid ? bus.a : '0;
      b_d[0]     = bus.in_valid ? (bus.sub ? ~bus.b : bus.b) : '0;
      cin0       = bus.in_valid & bus.cin;
      chunk[0]   = {1'b0, a_d[0][CW-1:0]} + {1'b0, b_d[0][CW-1:0]}
                 + {{CW{1'b0}}, cin0};
      s_d[0]     = '0;
      s_d[0][CW-1:0] = chunk[0][CW-1:0];
      c_d[0]     = chunk[0][CW];

      // Stage k: operands travel down unchanged, partial sum gains chunk k.
      for (int k = 1; k < STAGES; k++) begin
         valid_d[k] = valid_q[k-1];
         a_d[k]     = a_q[k-1];
         b_d[k]     = b_q[k-1];
         chunk[k]   = {1'b0, a_q[k-1][k*CW +: CW]} + {1'b0, b_q[k-1][k*CW +: CW]}
                    + {{CW{1'b0}}, c_q[k-1]};
         s_d[k]     = s_q[k-1];
         s_d[k][k*CW +: CW] = chunk[k][CW-1:0];
         c_d[k]     = chunk[k][CW];
      end

      // Flags are registered with the final stage; gating with valid keeps
      // zero low while bubbles (all-zero data) pass through.
      ovf_d  = valid_d[LAST] && (a_d[LAST][MSB] == b_d[LAST][MSB])
                             && (s_d[LAST][MSB] != a_d[LAST][MSB]);
      zero_d = valid_d[LAST] && (s_d[LAST] == '0);
      neg_d  = valid_d[LAST] && s_d[LAST][MSB];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         c_q     <= '0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
      end else if (adv) begin
         valid_q <= valid_d;
         c_q     <= c_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         neg_q   <= neg_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = valid_q[LAST];
   assign bus.sum       = s_q[LAST];
   assign bus.cout      = c_q[LAST];
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
   assign bus.neg       = neg_q;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_adder
// Purpose  : Self-checking bench for pipelined_adder. A 16/4 instance gets
//            directed, backpressure and reset cases; 32/1 and 32/8 instances
//            get random operand streams. Expected results come from a
//            golden add model through per-instance scoreboards.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;
   logic clk = 1'b0;
   logic rst;
   logic rst_sw;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   sw_done = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] v;
      int          c;
   } item_t;

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Golden model: packs {cout, ovf, zero, neg, sum} into one word.
   function automatic logic [63:0] model(input int w, input logic [31:0] a,
                                         input logic [31:0] b, input logic sub,
                                         input logic cin);
      logic [31:0] m, be, s, am;
      logic [32:0] full;
      logic        co, ov, z, n;
      m    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      am   = a & m;
      be   = (sub ? ~b : b) & m;
      full = {1'b0, am} + {1'b0, be} + {32'b0, cin};
      s    = full[31:0] & m;
      co   = full[w];
      ov   = (am[w-1] == be[w-1]) && (s[w-1] != am[w-1]);
      z    = (s == 32'h0);
      n    = s[w-1];
      return {28'b0, co, ov, z, n, s};
   endfunction

   // ------------------------------------------------------------------------
   // Main 16-bit / 4-stage instance
   // ------------------------------------------------------------------------
   pipelined_adder_if #(.WIDTH(16)) bus16 ();
   pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus16)
   );

   item_t       q16[$];
   bit          chk_lat = 1'b0;
   bit          was_stall = 1'b0;
   logic [63:0] held;
   int          n_pop16 = 0;

   function automatic logic [63:0] pack16();
      return {28'b0, bus16.cout, bus16.ovf, bus16.zero, bus16.neg, 16'b0, bus16.sum};
   endfunction

   task automatic cyc16(input bit iv, input logic [15:0] a, input logic [15:0] b,
                        input bit sub, input bit cin, input bit ordy, output bit acc);
      item_t       it;
      logic [63:0] cur;
      @(negedge clk);
      bus16.in_valid  = iv;
      bus16.a         = a;
      bus16.b         = b;
      bus16.sub       = sub;
      bus16.cin       = cin;
      bus16.out_ready = ordy;
      #1;
      chk_val("in_ready", {63'b0, bus16.in_ready}, {63'b0, !(bus16.out_valid && !bus16.out_ready)});
      cur = pack16();
      if (was_stall && bus16.out_valid) chk_val("stall_hold", cur, held);
      was_stall = bus16.out_valid && !bus16.out_ready;
      held      = cur;
      if (bus16.out_valid && bus16.out_ready) begin
         if (q16.size() == 0) begin
            chk_val("unexpected_out", 64'd1, 64'd0);
         end else begin
            it = q16.pop_front();
            n_pop16++;
            chk_val("result16", cur, it.v);
            if (chk_lat) chk_val("latency16", 64'(cyc - it.c), 64'd4);
         end
      end
      acc = bus16.in_valid && bus16.in_ready;
      if (acc) q16.push_back('{model(16, {16'b0, a}, {16'b0, b}, sub, cin), cyc});
   endtask

   task automatic idle16(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cyc16(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, acc);
   endtask

   task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit sub, input bit cin);
      bit acc;
      cyc16(1'b1, a, b, sub, cin, 1'b1, acc);
      chk_val("accept16", {63'b0, acc}, 64'd1);
   endtask

   // ------------------------------------------------------------------------
   // Random sweep instances: 32/1 and 32/8
   // ------------------------------------------------------------------------
   for (genvar g = 0; g < 2; g++) begin : g_sweep
      localparam int S = (g == 0) ? 1 : 8;

      pipelined_adder_if #(.WIDTH(32)) bus ();
      pipelined_adder #(.WIDTH(32), .STAGES(S)) dut_sw (
         .clk (clk),
         .rst (rst_sw),
         .bus (bus)
      );

      item_t q[$];

      initial begin
         int          acc_n;
         item_t       it;
         logic [31:0] ra, rb;
         bit          rs, rc;
         acc_n         = 0;
         bus.in_valid  = 1'b0;
         bus.a         = '0;
         bus.b         = '0;
         bus.sub       = 1'b0;
         bus.cin       = 1'b0;
         bus.out_ready = 1'b1;
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         rc = 1'($urandom_range(0, 1));
         repeat (3) @(negedge clk);
         for (int t = 0; t < 5000 && (acc_n < 1000 || q.size() > 0); t++) begin
            @(negedge clk);
            bus.in_valid = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
            bus.a   = ra;
            bus.b   = rb;
            bus.sub = rs;
            bus.cin = rc;
            #1;
            if (bus.out_valid) begin
               if (q.size() == 0) begin
                  chk_val("sw_unexpected_out", 64'd1, 64'd0);
               end else begin
                  it = q.pop_front();
                  chk_val("sw_result", {28'b0, bus.cout, bus.ovf, bus.zero, bus.neg, bus.sum}, it.v);
                  chk_val("sw_latency", 64'(cyc - it.c), 64'(S));
               end
            end
            if (bus.in_valid && bus.in_ready) begin
               q.push_back('{model(32, ra, rb, rs, rc), cyc});
               acc_n++;
               ra = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
               rb = ($urandom_range(0, 7) == 0) ? 32'h0000_0001 : $urandom;
               rs = 1'($urandom_range(0, 1));
               rc = 1'($urandom_range(0, 1));
            end
         end
         bus.in_valid = 1'b0;
         chk_val("sw_drain", 64'(q.size()), 64'd0);
         chk_val("sw_count", 64'(acc_n), 64'd1000);
         sw_done++;
      end
   end

   // ------------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------------
   initial begin
      bit acc;
      int i;
      rst             = 1'b1;
      rst_sw          = 1'b1;
      bus16.in_valid  = 1'b0;
      bus16.a         = '0;
      bus16.b         = '0;
      bus16.sub       = 1'b0;
      bus16.cin       = 1'b0;
      bus16.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst    = 1'b0;
      rst_sw = 1'b0;
      #1;
      chk_val("rst_out_valid", {63'b0, bus16.out_valid}, 64'd0);
      chk_val("rst_outputs", pack16(), 64'd0);
      chk_val("rst_in_ready", {63'b0, bus16.in_ready}, 64'd1);

      // Directed cases with latency checking
      chk_lat = 1'b1;
      op16(16'h1234, 16'h4321, 1'b0, 1'b0); idle16(6);
      op16(16'hFFFF, 16'h0001, 1'b0, 1'b0); idle16(6);
      op16(16'h7FFF, 16'h0001, 1'b0, 1'b0); idle16(6);
      op16(16'h0005, 16'h0007, 1'b1, 1'b1); idle16(6);
      op16(16'h8000, 16'h8000, 1'b0, 1'b1);
      op16(16'h0000, 16'h0000, 1'b1, 1'b0);
      op16(16'h00FF, 16'h0F01, 1'b0, 1'b1);
      idle16(6);
      chk_val("directed_drain", 64'(q16.size()), 64'd0);

      // Streaming with backpressure on stream cycles 5..8
      chk_lat = 1'b0;
      n_pop16 = 0;
      i = 0;
      for (int j = 0; j < 40 && (i < 8 || q16.size() > 0); j++) begin
         cyc16(i < 8, 16'(i), 16'(i * 16'h0101), 1'b0, 1'b0, !(j >= 5 && j <= 8), acc);
         if (acc) i++;
      end
      chk_val("stream_drain", 64'(q16.size()), 64'd0);
      chk_val("stream_count", 64'(n_pop16), 64'd8);

      // Fill and stall the pipe, then reset mid-stall
      i = 0;
      for (int j = 0; j < 10; j++) begin
         cyc16(1'b1, 16'hA000 + 16'(i), 16'h0111, 1'b0, 1'b0, 1'b0, acc);
         if (acc) i++;
      end
      chk_val("stall_out_valid", {63'b0, bus16.out_valid}, 64'd1);
      @(negedge clk);
      rst            = 1'b1;
      bus16.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_val("midrst_out_valid", {63'b0, bus16.out_valid}, 64'd0);
      chk_val("midrst_outputs", pack16(), 64'd0);
      chk_val("midrst_in_ready", {63'b0, bus16.in_ready}, 64'd1);
      q16.delete();
      was_stall = 1'b0;
      chk_lat   = 1'b1;
      n_pop16   = 0;
      op16(16'h1111, 16'h2222, 1'b0, 1'b0);
      idle16(6);
      chk_val("postrst_count", 64'(n_pop16), 64'd1);
      chk_val("postrst_drain", 64'(q16.size()), 64'd0);

      // Wait (bounded) for the random sweeps
      for (int t = 0; t < 20000 && sw_done < 2; t++) @(negedge clk);
      chk_val("sweep_done", 64'(sw_done), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined add/subtract unit for the ALU datapath, successor to the fixed 16-bit ripple-carry adder. It splits a WIDTH-bit operand pair into STAGES equal chunks and resolves one chunk per pipeline stage, passing the carry forward between stages. It provides valid/ready flow control, add/subtract mode, an explicit carry-in and NZCV-style flags, so it can sit between the operand-fetch and writeback stages.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
STAGES, 4, pipeline depth and number of carry chunks; range 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
clk        input   1      clock; all state updates on rising edge
rst        input   1      synchronous, active-high reset
in_valid   input   1      operand set present on a, b, sub, cin
in_ready   output  1      unit can accept an operand set this cycle
a          input   WIDTH  operand A
b          input   WIDTH  operand B
sub        input   1      0: a+b+cin; 1: a+~b+cin (drive cin=1 for plain a-b)
cin        input   1      carry-in to bit 0
out_valid  output  1      result/flags valid
out_ready  input   1      consumer accepts the result this cycle
sum        output  WIDTH  result, modulo 2^WIDTH
cout       output  1      carry out of MSB (for subtract: 1 = no borrow)
ovf        output  1      signed overflow
zero       output  1      sum == 0
neg        output  1      sum[WIDTH-1]

Behaviour:
- Global advance enable adv = !out_valid || out_ready; in_ready = adv (combinational). No bubble collapsing; the whole pipe stalls together.
- Accept when in_valid && in_ready. On accept, register a, b_eff = sub ? ~b : b, and cin into stage 0. Each stage carries a valid bit.
- Stage k (0..STAGES-1) adds chunk k of a and b_eff plus the incoming carry (cin for k=0, the registered carry from stage k-1 otherwise). It stores CW sum bits and the chunk carry. Operand chunks not yet consumed are carried (skewed) down the pipe; finished sum chunks are carried to the output.
- Latency: a result accepted at edge t presents out_valid=1 with the full sum/flags after edge t+STAGES-1 (i.e. STAGES register stages; STAGES=1 gives one cycle). Throughput is one result per cycle while out_ready=1.
- Flags are computed from the final stage: cout = carry from the last chunk; ovf = (a[MSB]==b_eff[MSB]) && (sum[MSB]!=a[MSB]); zero = (sum==0); neg = sum[MSB].
- Stall (out_valid && !out_ready): every stage register, including outputs, holds; in_ready=0; an input presented during the stall is not accepted and must be held by the source.
- Output hold: sum and flags are stable whenever out_valid=1 and out_ready=0.
- Simultaneous out_ready=1 and in_valid=1 with a full pipe: the output retires and the input enters stage 0 in the same edge; nothing is lost or duplicated.
- Ordering: strict FIFO; no reordering.
- Reset (any cycle, including mid-operation or mid-stall): all stage valid bits clear; all data registers clear to 0; out_valid=0, sum=0, cout=ovf=zero=neg=0 after the reset edge; in_ready=1 (combinational from out_valid=0). In-flight operations are discarded.
- Invalid stages carry don't-care data internally, but outputs must read 0 after reset until the first valid result arrives.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0x1234, b=0x4321, sub=0, cin=0 -> out_valid exactly 4 edges after accept; sum=0x5555, cout=0, ovf=0, zero=0, neg=0.
- Full carry ripple across all chunks: a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0, neg=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, ovf=1, neg=1, cout=0; subtract a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, neg=1, ovf=0.
- Streaming with backpressure: 8 back-to-back ops (a=i, b=i*0x0101), out_ready low for cycles 5-8 -> in_ready low exactly while out_valid && !out_ready; 8 results in order, each equal to a+b; no drops or duplicates; outputs stable during stall.
- Reset mid-stream: pipe full and stalled, assert rst one cycle -> out_valid=0, sum/flags=0 after the edge, in_ready=1; the next accepted op returns its correct result after STAGES cycles.
- Parameter sweep: WIDTH=32/STAGES=1 and WIDTH=32/STAGES=8 with 1000 random ops including sub/cin -> all results match a golden model; latency equals STAGES.
